// File: rtl/load_counter_arbiter_if.sv
// load_counter_arbiter_if
//   Bundles the requester-side signals of the shared counter arbiter.
//   Ports / signals:
//     req          per-requester request, held until that requester's done
//     req_load     per-requester start value, slice i = [i*CNT_W +: CNT_W]
//     grant        one-hot current owner of the counter (zero when idle)
//     done         one-cycle completion pulse to the owner
//     busy         high while the counter is owned
//     counter_out  current counter value
//   Modports: master = requester side, slave = arbiter side.
interface load_counter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_load;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [CNT_W-1:0]         counter_out;

    modport master (
        output req,
        output req_load,
        input  grant,
        input  done,
        input  busy,
        input  counter_out
    );

    modport slave (
        input  req,
        input  req_load,
        output grant,
        output done,
        output busy,
        output counter_out
    );
endinterface

// File: rtl/load_counter_arbiter.sv
// load_counter_arbiter
//   Shares one loadable up-counter between NUM_REQ requesters. A round-robin
//   arbiter picks a winner in IDLE, loads its start value, counts up to all
//   ones, then pulses done to the winner for one cycle before releasing.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   slave side of load_counter_arbiter_if (req/req_load in,
//           grant/done/busy/counter_out out, all outputs registered)
module load_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    load_counter_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int                   cand;

    // Round-robin search: first set req bit starting at the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && bus.req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = done_q;
        counter_d = counter_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d   = NUM_REQ'(1) << win_idx;
                    counter_d = bus.req_load[win_idx*CNT_W +: CNT_W];
                    owner_d   = win_idx;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                // Terminal count holds the counter and raises done on the
                // owner's bit only, so done can never leave the grant.
                if (counter_q == MAX) begin
                    done_d  = grant_q;
                    state_d = DONE;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = '0;
                grant_d = '0;
                ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            counter_q <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            counter_q <= counter_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.busy        = |grant_q;
    assign bus.counter_out = counter_q;
endmodule

// File: tb/tb_load_counter_arbiter.sv
// tb_load_counter_arbiter
//   Directed bench for load_counter_arbiter with hand-computed expectations.
module tb_load_counter_arbiter;
    logic clk;
    logic rst;

    int nCompared = 0;
    int nMismatch = 0;

    load_counter_arbiter_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

    load_counter_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Check every observable output against one expected snapshot.
    task automatic checkState(input string tag, input logic [3:0] g,
                              input logic [3:0] d, input logic [3:0] c);
        checkOutput($sformatf("%s.grant", tag), 32'(bus.grant), 32'(g));
        checkOutput($sformatf("%s.done", tag), 32'(bus.done), 32'(d));
        checkOutput($sformatf("%s.busy", tag), 32'(bus.busy), 32'(|g));
        checkOutput($sformatf("%s.cnt", tag), 32'(bus.counter_out), 32'(c));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l);
        bus.req      = r;
        bus.req_load = l;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'b0000, 16'h0000);

        // 1: async reset with no clock edge
        #3 rst = 1'b1;
        #1 checkState("t1_async_rst", 4'b0000, 4'b0000, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        checkState("t1_idle", 4'b0000, 4'b0000, 4'h0);

        // 2: requester 1, load 10 -> seven grant cycles, done in the last
        applyStimulus(4'b0010, 16'h00A0);
        tick();
        checkState("t2_load", 4'b0010, 4'b0000, 4'hA);
        for (int v = 11; v <= 15; v++) begin
            tick();
            checkState($sformatf("t2_cnt%0d", v), 4'b0010, 4'b0000, 4'(v));
        end
        tick();
        checkState("t2_done", 4'b0010, 4'b0010, 4'hF);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkState("t2_release", 4'b0000, 4'b0000, 4'hF);

        // 3: requester 0, load MAX -> two grant cycles
        applyStimulus(4'b0001, 16'h000F);
        tick();
        checkState("t3_load", 4'b0001, 4'b0000, 4'hF);
        tick();
        checkState("t3_done", 4'b0001, 4'b0001, 4'hF);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkState("t3_release", 4'b0000, 4'b0000, 4'hF);

        // 4: fresh reset so the pointer starts at 0, then all four compete
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        applyStimulus(4'b1111, 16'hCCCC);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkState($sformatf("t4_j%0d_load", k), 4'(1 << k), 4'b0000, 4'hC);
            for (int v = 13; v <= 15; v++) begin
                tick();
                checkState($sformatf("t4_j%0d_cnt%0d", k, v), 4'(1 << k), 4'b0000, 4'(v));
            end
            tick();
            checkState($sformatf("t4_j%0d_done", k), 4'(1 << k), 4'(1 << k), 4'hF);
            bus.req[k] = 1'b0;
            tick();
            checkState($sformatf("t4_j%0d_gap", k), 4'b0000, 4'b0000, 4'hF);
        end
        // Pointer wrapped to 0; requester 0 wins, then 2 while 0101 stays held.
        applyStimulus(4'b0101, 16'hCCCC);
        tick();
        checkState("t4_wrap_load", 4'b0001, 4'b0000, 4'hC);
        tick();
        tick();
        tick();
        tick();
        checkState("t4_wrap_done", 4'b0001, 4'b0001, 4'hF);
        tick();
        checkState("t4_wrap_gap", 4'b0000, 4'b0000, 4'hF);
        tick();
        checkState("t4_next_load", 4'b0100, 4'b0000, 4'hC);
        tick();
        tick();
        tick();
        tick();
        checkState("t4_next_done", 4'b0100, 4'b0100, 4'hF);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkState("t4_next_gap", 4'b0000, 4'b0000, 4'hF);

        // 5: abort a running job with async reset at count 12
        applyStimulus(4'b0100, 16'h0900);
        tick();
        checkState("t5_load", 4'b0100, 4'b0000, 4'h9);
        tick();
        tick();
        tick();
        checkState("t5_cnt12", 4'b0100, 4'b0000, 4'hC);
        #2 rst = 1'b1;
        #1 checkState("t5_abort", 4'b0000, 4'b0000, 4'h0);
        applyStimulus(4'b0011, 16'h000F);
        #1 rst = 1'b0;
        tick();
        checkState("t5_regrant", 4'b0001, 4'b0000, 4'hF);
        tick();
        checkState("t5_done", 4'b0001, 4'b0001, 4'hF);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkState("t5_release", 4'b0000, 4'b0000, 4'hF);

        // 6: request dropped and load changed after the grant edge
        applyStimulus(4'b1000, 16'hD000);
        tick();
        checkState("t6_load", 4'b1000, 4'b0000, 4'hD);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkState("t6_cnt14", 4'b1000, 4'b0000, 4'hE);
        tick();
        checkState("t6_cnt15", 4'b1000, 4'b0000, 4'hF);
        tick();
        checkState("t6_done", 4'b1000, 4'b1000, 4'hF);
        tick();
        checkState("t6_release", 4'b0000, 4'b0000, 4'hF);
        tick();
        checkState("t6_no_regrant", 4'b0000, 4'b0000, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
